// File: rtl/dsp48a1_pkg.sv
// Shared widths, OPMODE field positions and X/Z mux encodings for the DSP slice.
package dsp48a1_pkg;

  localparam int OPND_W = 18;
  localparam int MULT_W = 36;
  localparam int ACC_W  = 48;

  // OPMODE bit positions
  localparam int OP_X_LO   = 0;
  localparam int OP_X_HI   = 1;
  localparam int OP_Z_LO   = 2;
  localparam int OP_Z_HI   = 3;
  localparam int OP_PRE_EN = 4;
  localparam int OP_CYI    = 5;
  localparam int OP_PRE_SUB = 6;
  localparam int OP_POST_SUB = 7;

  typedef enum logic [1:0] {
    X_ZERO = 2'd0,
    X_M    = 2'd1,
    X_P    = 2'd2,
    X_DAB  = 2'd3
  } xsel_e;

  typedef enum logic [1:0] {
    Z_ZERO = 2'd0,
    Z_PCIN = 2'd1,
    Z_P    = 2'd2,
    Z_C    = 2'd3
  } zsel_e;

endpackage

// File: rtl/dsp_pipe_reg.sv
// Optional pipeline stage: clock-enabled register with async active-low clear, or a plain wire.
module dsp_pipe_reg #(
  parameter int WIDTH  = 18,
  parameter int EN_REG = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (EN_REG != 0) begin : g_reg
      // Clear has priority over the clock enable
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (ce) q <= d;
      end
    end else begin : g_wire
      // Control pins are intentionally ignored when the stage is bypassed
      logic unused_ctl;
      assign unused_ctl = &{1'b0, clk, rst_n, ce};
      assign q = d;
    end
  endgenerate

endmodule

// File: rtl/dsp48a1_slice.sv
// DSP slice: pre-adder, 18x18 unsigned multiplier, 48-bit post-adder/accumulator, cascade ports.
module dsp48a1_slice
  import dsp48a1_pkg::*;
#(
  parameter int A0REG       = 0,
  parameter int A1REG       = 1,
  parameter int B0REG       = 0,
  parameter int B1REG       = 1,
  parameter int CREG        = 1,
  parameter int DREG        = 1,
  parameter int MREG        = 1,
  parameter int PREG        = 1,
  parameter int CARRYINREG  = 1,
  parameter int CARRYOUTREG = 1,
  parameter int OPMODEREG   = 1,
  parameter     CARRYINSEL  = "OPMODE5",
  parameter     B_INPUT     = "DIRECT"
) (
  input  logic              clk,
  input  logic              rsta,
  input  logic              rstb,
  input  logic              rstc,
  input  logic              rstd,
  input  logic              rstm,
  input  logic              rstp,
  input  logic              rstopmode,
  input  logic              rstcarrin,
  input  logic              cea,
  input  logic              ceb,
  input  logic              cec,
  input  logic              ced,
  input  logic              cem,
  input  logic              cep,
  input  logic              ceopmode,
  input  logic              cecarryin,
  input  logic [OPND_W-1:0] A,
  input  logic [OPND_W-1:0] B,
  input  logic [OPND_W-1:0] D,
  input  logic [OPND_W-1:0] BCIN,
  input  logic [ACC_W-1:0]  C,
  input  logic [ACC_W-1:0]  PCIN,
  input  logic              CARRYIN,
  input  logic [7:0]        opmode,
  output logic [OPND_W-1:0] BCOUT,
  output logic [ACC_W-1:0]  PCOUT,
  output logic [ACC_W-1:0]  P,
  output logic [MULT_W-1:0] M,
  output logic              CARRYOUT,
  output logic              CARRYOUTF
);

  localparam bit B_CASC  = (B_INPUT == "CASCADE");
  localparam bit B_DIR   = (B_INPUT == "DIRECT");
  localparam bit CY_OP5  = (CARRYINSEL == "OPMODE5");
  localparam bit CY_PORT = (CARRYINSEL == "CARRYIN");

  logic [OPND_W-1:0] b_src, a0, b0, d_r, pre, b1_d, a1, b1;
  logic [ACC_W-1:0]  c_r, x, z, p_r;
  logic [MULT_W-1:0] mult, m_r;
  logic [7:0]        op;
  logic              cyi_src, cyi, cyo;
  logic [ACC_W:0]    post;

  // Unknown source selections fall back to zero
  assign b_src   = B_CASC ? BCIN : (B_DIR ? B : '0);
  assign cyi_src = CY_OP5 ? opmode[OP_CYI] : (CY_PORT ? CARRYIN : 1'b0);

  dsp_pipe_reg #(.WIDTH(OPND_W), .EN_REG(A0REG)) u_a0 (.clk(clk), .rst_n(rsta), .ce(cea), .d(A), .q(a0));
  dsp_pipe_reg #(.WIDTH(OPND_W), .EN_REG(B0REG)) u_b0 (.clk(clk), .rst_n(rstb), .ce(ceb), .d(b_src), .q(b0));
  dsp_pipe_reg #(.WIDTH(OPND_W), .EN_REG(DREG))  u_d  (.clk(clk), .rst_n(rstd), .ce(ced), .d(D), .q(d_r));
  dsp_pipe_reg #(.WIDTH(ACC_W),  .EN_REG(CREG))  u_c  (.clk(clk), .rst_n(rstc), .ce(cec), .d(C), .q(c_r));
  dsp_pipe_reg #(.WIDTH(8), .EN_REG(OPMODEREG))
    u_op (.clk(clk), .rst_n(rstopmode), .ce(ceopmode), .d(opmode), .q(op));

  // Pre-adder wraps at 18 bits; op[4] chooses it over the raw B path
  assign pre  = op[OP_PRE_SUB] ? (d_r - b0) : (d_r + b0);
  assign b1_d = op[OP_PRE_EN] ? pre : b0;

  dsp_pipe_reg #(.WIDTH(OPND_W), .EN_REG(A1REG)) u_a1 (.clk(clk), .rst_n(rsta), .ce(cea), .d(a0), .q(a1));
  dsp_pipe_reg #(.WIDTH(OPND_W), .EN_REG(B1REG)) u_b1 (.clk(clk), .rst_n(rstb), .ce(ceb), .d(b1_d), .q(b1));

  assign mult = {{(MULT_W-OPND_W){1'b0}}, a1} * {{(MULT_W-OPND_W){1'b0}}, b1};

  dsp_pipe_reg #(.WIDTH(MULT_W), .EN_REG(MREG)) u_m (.clk(clk), .rst_n(rstm), .ce(cem), .d(mult), .q(m_r));

  // X/Z operand routing; P feedback gives accumulation
  always_comb begin
    x = '0;
    z = '0;
    case (xsel_e'(op[OP_X_HI:OP_X_LO]))
      X_ZERO:  x = '0;
      X_M:     x = {{(ACC_W-MULT_W){1'b0}}, m_r};
      X_P:     x = p_r;
      X_DAB:   x = {d_r[11:0], a1, b1};
      default: x = '0;
    endcase
    case (zsel_e'(op[OP_Z_HI:OP_Z_LO]))
      Z_ZERO:  z = '0;
      Z_PCIN:  z = PCIN;
      Z_P:     z = p_r;
      Z_C:     z = c_r;
      default: z = '0;
    endcase
  end

  dsp_pipe_reg #(.WIDTH(1), .EN_REG(CARRYINREG))
    u_cyi (.clk(clk), .rst_n(rstcarrin), .ce(cecarryin), .d(cyi_src), .q(cyi));

  // 49-bit post-adder; bit 48 is carry on add, borrow on subtract
  assign post = op[OP_POST_SUB] ? ({1'b0, z} - ({1'b0, x} + {{ACC_W{1'b0}}, cyi}))
                                : ({1'b0, z} + {1'b0, x} + {{ACC_W{1'b0}}, cyi});

  dsp_pipe_reg #(.WIDTH(ACC_W), .EN_REG(PREG))
    u_p (.clk(clk), .rst_n(rstp), .ce(cep), .d(post[ACC_W-1:0]), .q(p_r));
  dsp_pipe_reg #(.WIDTH(1), .EN_REG(CARRYOUTREG))
    u_cyo (.clk(clk), .rst_n(rstcarrin), .ce(cecarryin), .d(post[ACC_W]), .q(cyo));

  assign BCOUT     = b1;
  assign M         = m_r;
  assign P         = p_r;
  assign PCOUT     = p_r;
  assign CARRYOUT  = cyo;
  assign CARRYOUTF = cyo;

endmodule

// File: tb/tb_dsp48a1_slice.sv
// Scoreboard bench for the DSP slice: expected results queued at drive time, popped when sampled.
module tb_dsp48a1_slice;

  logic        clk = 1'b0;
  logic        rsta, rstb, rstc, rstd, rstm, rstp, rstopmode, rstcarrin;
  logic        cea, ceb, cec, ced, cem, cep, ceopmode, cecarryin;
  logic [17:0] A, B, D, BCIN;
  logic [47:0] C, PCIN;
  logic        CARRYIN;
  logic [7:0]  opmode;
  logic [17:0] BCOUT;
  logic [47:0] PCOUT, P;
  logic [35:0] M;
  logic        CARRYOUT, CARRYOUTF;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic [47:0] p;
    logic [35:0] m;
    logic [17:0] bc;
    logic        co;
    bit          all;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  dsp48a1_slice dut (
    .clk(clk), .rsta(rsta), .rstb(rstb), .rstc(rstc), .rstd(rstd), .rstm(rstm), .rstp(rstp),
    .rstopmode(rstopmode), .rstcarrin(rstcarrin),
    .cea(cea), .ceb(ceb), .cec(cec), .ced(ced), .cem(cem), .cep(cep),
    .ceopmode(ceopmode), .cecarryin(cecarryin),
    .A(A), .B(B), .D(D), .BCIN(BCIN), .C(C), .PCIN(PCIN), .CARRYIN(CARRYIN), .opmode(opmode),
    .BCOUT(BCOUT), .PCOUT(PCOUT), .P(P), .M(M), .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF)
  );

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rst(input logic v);
    {rsta, rstb, rstc, rstd, rstm, rstp, rstopmode, rstcarrin} = {8{v}};
  endtask

  task automatic set_ce(input logic v);
    {cea, ceb, cec, ced, cem, cep, ceopmode, cecarryin} = {8{v}};
  endtask

  task automatic push(input string tag, input logic [47:0] p, input logic [35:0] m,
                      input logic [17:0] bc, input logic co, input bit all);
    exp_t e;
    e.tag = tag; e.p = p; e.m = m; e.bc = bc; e.co = co; e.all = all;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".P"}, P, e.p);
      chk({e.tag, ".PCOUT"}, PCOUT, e.p);
      if (e.all) begin
        chk({e.tag, ".M"}, {12'b0, M}, {12'b0, e.m});
        chk({e.tag, ".BCOUT"}, {30'b0, BCOUT}, {30'b0, e.bc});
        chk({e.tag, ".CARRYOUT"}, {47'b0, CARRYOUT}, {47'b0, e.co});
        chk({e.tag, ".CARRYOUTF"}, {47'b0, CARRYOUTF}, {47'b0, e.co});
      end
    end
  endtask

  initial begin
    A = '0; B = '0; D = '0; BCIN = '0; C = '0; PCIN = '0; CARRYIN = 1'b0; opmode = '0;
    set_rst(1'b0);
    set_ce(1'b1);
    tick(2);
    push("reset", 48'd0, 36'd0, 18'd0, 1'b0, 1'b1);
    drain();

    // Released but all enables off: nothing may load
    set_rst(1'b1);
    set_ce(1'b0);
    A = 18'd3; B = 18'd5; D = 18'd10; C = 48'd100; opmode = 8'b0001_1101;
    tick(4);
    push("ce_off", 48'd0, 36'd0, 18'd0, 1'b0, 1'b1);
    drain();

    // D+B pre-add, multiply by A, add C
    set_ce(1'b1);
    tick(6);
    push("madd", 48'd145, 36'd45, 18'd15, 1'b0, 1'b1);
    drain();

    // D-B pre-sub, C minus product
    opmode = 8'b1101_1101;
    tick(6);
    push("presub", 48'd85, 36'd15, 18'd5, 1'b0, 1'b1);
    drain();

    // X = {D[11:0], A1, B1}
    opmode = 8'b0000_0011; D = 18'h00ABC; A = 18'd1; B = 18'd2;
    tick(6);
    push("concat", {12'hABC, 18'd1, 18'd2}, 36'd2, 18'd2, 1'b0, 1'b1);
    drain();

    // C all-ones plus carry-in from op[5] wraps to zero with carry out
    opmode = 8'b0010_1100; C = 48'hFFFF_FFFF_FFFF;
    tick(6);
    push("carry", 48'd0, 36'd2, 18'd2, 1'b1, 1'b1);
    drain();

    // Accumulate P += A*B with P held in reset while the pipe settles
    opmode = 8'b0000_1001; A = 18'd2; B = 18'd3; rstp = 1'b0;
    tick(5);
    push("acc_hold", 48'd0, 36'd6, 18'd3, 1'b0, 1'b1);
    drain();
    rstp = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick(1);
      push($sformatf("acc%0d", k), 48'(6 * k), 36'd0, 18'd0, 1'b0, 1'b0);
      drain();
    end

    // Async clear between edges
    #2 rstp = 1'b0;
    #1;
    push("acc_async_clr", 48'd0, 36'd0, 18'd0, 1'b0, 1'b0);
    drain();
    rstp = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      tick(1);
      push($sformatf("acc_restart%0d", k), 48'(6 * k), 36'd0, 18'd0, 1'b0, 1'b0);
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
